// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the channel FSM state
// encodings used by both the master and the register-bank slave.
package axi4_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}                 rd_state_e;
endpackage

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating the master's bus on a bank of word registers,
// with independent write (AW/W/B) and read (AR/R) FSMs.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  localparam int NUM_REGS = 2 ** (ADDR_W - 2),
  localparam int IDX_W    = ADDR_W - 2
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   slv_reg
);

  wr_state_e          wstate;
  rd_state_e          rstate;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [IDX_W-1:0]   aidx;
  logic [DATA_W-1:0]  wdat;
  logic [DATA_W-1:0]  rdata_q;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_hs, w_hs, ar_hs;
  logic             unused_lsb;

  assign aw_idx     = AWADDR[ADDR_W-1:2];
  assign ar_idx     = ARADDR[ADDR_W-1:2];
  assign unused_lsb = ^{AWADDR[1:0], ARADDR[1:0]};

  // Readies and valids decode from state only; reset forces them low even
  // before the first reset edge has been seen.
  assign AWREADY = !ARESET && (wstate == W_IDLE || wstate == W_DATA);
  assign WREADY  = !ARESET && (wstate == W_IDLE || wstate == W_ADDR);
  assign BVALID  = !ARESET && (wstate == W_RESP);
  assign ARREADY = !ARESET && (rstate == R_IDLE);
  assign RVALID  = !ARESET && (rstate == R_DATA);
  assign RDATA   = ARESET ? '0 : rdata_q;
  assign BRESP   = RESP_OKAY;
  assign RRESP   = RESP_OKAY;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID  && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      rstate  <= R_IDLE;
      aidx    <= '0;
      wdat    <= '0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            regs[aw_idx] <= WDATA;
            wstate       <= W_RESP;
          end else if (aw_hs) begin
            aidx   <= aw_idx;
            wstate <= W_ADDR;
          end else if (w_hs) begin
            wdat   <= WDATA;
            wstate <= W_DATA;
          end
        end
        W_ADDR: if (w_hs) begin
          regs[aidx] <= WDATA;
          wstate     <= W_RESP;
        end
        W_DATA: if (aw_hs) begin
          regs[aw_idx] <= wdat;
          wstate       <= W_RESP;
        end
        W_RESP: if (BREADY) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase

      // Same-edge read of a register being written returns the old value.
      case (rstate)
        R_IDLE: if (ar_hs) begin
          rdata_q <= regs[ar_idx];
          rstate  <= R_DATA;
        end
        R_DATA: if (RREADY) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign slv_reg[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave register bank that terminates the bus driven by the team's AXI4-Lite master. It accepts write address (AW), write data (W) and write response (B) transactions, plus read address (AR) and read data (R) transactions, against a bank of word registers. All register contents are exported in parallel to downstream peripheral logic. It is the consuming stage directly downstream of the master's AW/W/B channel FSMs.

## Interface
Parameters:
- ADDR_W, 4, byte-address width; register count NUM_REGS = 2**(ADDR_W-2) = 4
- DATA_W, 32, data width; fixed at 32 for this revision

Ports:
- ACLK  in  1  single clock; everything is sampled on the rising edge
- ARESET  in  1  synchronous, active-high reset
- AWADDR  in  ADDR_W  write byte address; bits [1:0] are ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_W  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response, always 2'b00 (OKAY)
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_W  read byte address; bits [1:0] are ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response, always 2'b00
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- slv_reg  out  NUM_REGS×DATA_W  packed register contents; reg i occupies bits [32i+31:32i]

## Operation
- Register index is addr[ADDR_W-1:2]. Every address decodes to a register; there is no SLVERR path.
- A handshake occurs on a cycle where VALID and READY are both high at the rising edge.

Write FSM (states W_IDLE, W_ADDR, W_DATA, W_RESP):
- W_IDLE: AWREADY=1, WREADY=1.
  - AW and W in the same cycle: the register is written at that edge, then go to W_RESP.
  - AW only: latch AWADDR, go to W_ADDR.
  - W only: latch WDATA, go to W_DATA.
- W_ADDR: AWREADY=0, WREADY=1. On the W handshake, write WDATA to the latched address, go to W_RESP.
- W_DATA: AWREADY=1, WREADY=0. On the AW handshake, write the latched data to AWADDR, go to W_RESP.
- W_RESP: both readies low, BVALID=1, BRESP=00. On BREADY, go to W_IDLE.
- BVALID holds until BREADY, however long that takes. No new AW or W is accepted while in W_RESP.

Read FSM (states R_IDLE, R_DATA):
- R_IDLE: ARREADY=1. On the AR handshake, capture RDATA <= reg[index], go to R_DATA.
- R_DATA: ARREADY=0, RVALID=1, and RDATA stays stable. On RREADY, go to R_IDLE.

The read and write FSMs are fully independent. A read and a write that both target the same register in the same cycle return the pre-write value.

## Timing
- ARESET high at an edge: all registers clear to 0, both FSMs return to idle, and any latched address or data is discarded.
- While ARESET is high: AWREADY, WREADY, ARREADY, BVALID and RVALID are all 0; RDATA=0; BRESP=RRESP=00.
- The first cycle after ARESET deasserts shows the idle readies at 1.
- Mid-transaction reset aborts without a response, even when a B or R beat is pending.
- Write latency: slv_reg updates at the edge where the second of AW/W handshakes. BVALID rises in the next cycle.
- Minimum write period is 2 cycles (handshake, then B with BREADY=1).
- Read latency: RVALID is high the cycle after the AR handshake. Minimum read period is 2 cycles.
- Ready signals depend only on state, never combinationally on VALID inputs.
- An upstream master that waits for BVALID while holding BREADY completes normally. An early BREADY with BVALID=0 has no effect.

## Structure
- Shared package axi4_lite_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - the write and read state enums, also reused by the master
- Single module, no sub-module. The register bank is an unpacked array inside the block, flattened onto slv_reg.

## Test plan
- Reset: hold ARESET 2 cycles after random writes -> all slv_reg=0, all VALIDs 0, idle readies 1 the cycle after release.
- Simultaneous write: AWADDR=4'h4, WDATA=32'hDEADBEEF, both valid in one cycle, BREADY=1 -> slv_reg[63:32]=32'hDEADBEEF at that edge, BVALID one cycle later for exactly 1 cycle, BRESP=00.
- Split order, each direction:
  - AW 4'hC first, W 32'h12345678 three cycles later -> reg3 written only on the W edge.
  - W first, AW 4'h8 later -> reg2 written only on the AW edge.
- B backpressure: hold BREADY=0 for 5 cycles -> BVALID stays 1 and AWREADY/WREADY stay 0; the cycle after BREADY rises, both readies return to 1.
- Read with backpressure: after writing reg1=32'hA5A5A5A5, send ARADDR=4'h5 (low bits ignored) with RREADY low 3 cycles -> RVALID held, RDATA=32'hA5A5A5A5 stable.
- Concurrent read/write: read reg0 (holding 32'h1) while writing reg0=32'h2 in the same cycle -> RDATA=32'h1, then a subsequent read returns 32'h2.
